// File: rtl/hv_bundle_seq_pkg.sv
// Shared types for the HV bundle sequencer: FSM state encoding and the
// smallest bundle size the bundler can complete.
package hv_bundle_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_WAIT,
        S_ISSUE,
        S_HOLD,
        S_DONE_WAIT,
        S_RES_WAIT,
        S_WRITE
    } BundleSeq_State_t;

    localparam int MIN_NUM_HV = 2;

endpackage

// File: rtl/hv_bundle_sequencer.sv
// Streams element d of every hypervector into the bundler as one bundle,
// then writes the bundled result to result-memory address d, for all d.
module hv_bundle_sequencer
    import hv_bundle_seq_pkg::*;
#(
    parameter int HV_DATA_WIDTH = 32,
    parameter int HV_DIM        = 1024,
    parameter int ADDR_WIDTH    = 16,
    parameter int CNT_WIDTH     = 8,
    parameter int RD_LAT        = 1,
    parameter int RES_LAT       = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      base_addr,
    input  logic [CNT_WIDTH-1:0]       num_hv,
    output logic                       busy,
    output logic                       finished,
    output logic                       error,
    output logic                       rd_en,
    output logic [ADDR_WIDTH-1:0]      rd_addr,
    input  logic [HV_DATA_WIDTH-1:0]   rd_data,
    output logic                       bnd_valid,
    output logic                       bnd_first,
    output logic                       bnd_last,
    output logic [HV_DATA_WIDTH-1:0]   bnd_data,
    input  logic                       bnd_ready,
    input  logic                       bnd_done,
    input  logic [HV_DATA_WIDTH-1:0]   bnd_data_out,
    output logic                       wr_en,
    output logic [$clog2(HV_DIM)-1:0]  wr_addr,
    output logic [HV_DATA_WIDTH-1:0]   wr_data
);

    localparam int DIM_W   = $clog2(HV_DIM);
    localparam int LAT_MAX = (RD_LAT > RES_LAT) ? RD_LAT : RES_LAT;
    localparam int LAT_W   = (LAT_MAX < 2) ? 1 : $clog2(LAT_MAX);

    localparam logic [LAT_W-1:0]      RD_WAIT_INIT  = LAT_W'(RD_LAT - 1);
    localparam logic [LAT_W-1:0]      RES_WAIT_INIT = LAT_W'(RES_LAT - 1);
    localparam logic [DIM_W-1:0]      D_LAST        = DIM_W'(HV_DIM - 1);
    localparam logic [ADDR_WIDTH-1:0] K_STRIDE      = ADDR_WIDTH'(HV_DIM);
    localparam logic [CNT_WIDTH-1:0]  NUM_MIN       = CNT_WIDTH'(MIN_NUM_HV);

    BundleSeq_State_t r_state;
    BundleSeq_State_t w_state_nxt;

    logic [ADDR_WIDTH-1:0]    r_col_addr;
    logic [ADDR_WIDTH-1:0]    r_elem_addr;
    logic [CNT_WIDTH-1:0]     r_num_hv;
    logic [CNT_WIDTH-1:0]     r_k;
    logic [DIM_W-1:0]         r_d;
    logic [LAT_W-1:0]         r_cnt;
    logic [HV_DATA_WIDTH-1:0] r_bnd_data;
    logic [HV_DATA_WIDTH-1:0] r_wr_data;

    logic r_busy, r_finished, r_error, r_rd_en;
    logic r_bnd_valid, r_bnd_first, r_bnd_last, r_wr_en;

    logic w_busy_nxt, w_finished_nxt, w_error_nxt, w_rd_en_nxt;
    logic w_bnd_valid_nxt, w_bnd_first_nxt, w_bnd_last_nxt, w_wr_en_nxt;

    logic w_start_ok, w_start_bad, w_k_last, w_d_last, w_cnt_zero;

    assign w_start_ok  = (r_state == S_IDLE) && start && (num_hv >= NUM_MIN);
    assign w_start_bad = (r_state == S_IDLE) && start && (num_hv < NUM_MIN);
    assign w_k_last    = (r_k == r_num_hv - CNT_WIDTH'(1));
    assign w_d_last    = (r_d == D_LAST);
    assign w_cnt_zero  = (r_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (w_start_ok) w_state_nxt = S_RD;
            S_RD:        w_state_nxt = S_RD_WAIT;
            S_RD_WAIT:   if (w_cnt_zero) w_state_nxt = S_ISSUE;
            S_ISSUE:     if (bnd_ready) w_state_nxt = S_HOLD;
            S_HOLD:      w_state_nxt = w_k_last ? S_DONE_WAIT : S_RD;
            S_DONE_WAIT: if (bnd_done) w_state_nxt = S_RES_WAIT;
            S_RES_WAIT:  if (w_cnt_zero) w_state_nxt = S_WRITE;
            S_WRITE:     w_state_nxt = w_d_last ? S_IDLE : S_RD;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // Output flops are loaded from the next state so every strobe is registered.
    always_comb begin
        w_rd_en_nxt     = (w_state_nxt == S_RD);
        w_bnd_valid_nxt = (r_state == S_ISSUE) && bnd_ready;
        w_bnd_first_nxt = w_bnd_valid_nxt && (r_k == '0);
        w_bnd_last_nxt  = r_bnd_last;
        if (w_bnd_valid_nxt && w_k_last)
            w_bnd_last_nxt = 1'b1;
        else if (w_state_nxt == S_WRITE)
            w_bnd_last_nxt = 1'b0;
        w_wr_en_nxt     = (w_state_nxt == S_WRITE);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
        w_finished_nxt  = (r_state == S_WRITE) && w_d_last;
        w_error_nxt     = w_start_bad;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_en     <= 1'b0;
            r_bnd_valid <= 1'b0;
            r_bnd_first <= 1'b0;
            r_bnd_last  <= 1'b0;
            r_wr_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_finished  <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_rd_en     <= w_rd_en_nxt;
            r_bnd_valid <= w_bnd_valid_nxt;
            r_bnd_first <= w_bnd_first_nxt;
            r_bnd_last  <= w_bnd_last_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_busy      <= w_busy_nxt;
            r_finished  <= w_finished_nxt;
            r_error     <= w_error_nxt;
        end
    end

    // Addressing steps by HV_DIM per hypervector and by one per dimension,
    // so base + k*HV_DIM + d never needs a multiplier.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col_addr  <= '0;
            r_elem_addr <= '0;
            r_num_hv    <= '0;
            r_k         <= '0;
            r_d         <= '0;
            r_cnt       <= '0;
            r_bnd_data  <= '0;
            r_wr_data   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_num_hv    <= num_hv;
                        r_col_addr  <= base_addr;
                        r_elem_addr <= base_addr;
                        r_k         <= '0;
                        r_d         <= '0;
                    end
                end
                S_RD: r_cnt <= RD_WAIT_INIT;
                S_RD_WAIT: begin
                    if (w_cnt_zero) r_bnd_data <= rd_data;
                    else            r_cnt      <= r_cnt - LAT_W'(1);
                end
                S_HOLD: begin
                    if (!w_k_last) begin
                        r_k         <= r_k + CNT_WIDTH'(1);
                        r_elem_addr <= r_elem_addr + K_STRIDE;
                    end
                end
                S_DONE_WAIT: r_cnt <= RES_WAIT_INIT;
                S_RES_WAIT: begin
                    if (w_cnt_zero) r_wr_data <= bnd_data_out;
                    else            r_cnt     <= r_cnt - LAT_W'(1);
                end
                S_WRITE: begin
                    if (!w_d_last) begin
                        r_d         <= r_d + DIM_W'(1);
                        r_k         <= '0;
                        r_col_addr  <= r_col_addr + ADDR_WIDTH'(1);
                        r_elem_addr <= r_col_addr + ADDR_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = r_busy;
    assign finished  = r_finished;
    assign error     = r_error;
    assign rd_en     = r_rd_en;
    assign rd_addr   = r_elem_addr;
    assign bnd_valid = r_bnd_valid;
    assign bnd_first = r_bnd_first;
    assign bnd_last  = r_bnd_last;
    assign bnd_data  = r_bnd_data;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_d;
    assign wr_data   = r_wr_data;

endmodule

// File: tb/tb_hv_bundle_sequencer.sv
// Directed bench for hv_bundle_sequencer with a source memory and a
// cycle-level bundler model (integer-sum or IEEE-754 single-sum mode).
module tb_hv_bundle_sequencer;

    localparam int DW  = 32;
    localparam int DIM = 4;
    localparam int AW  = 16;
    localparam int CW  = 8;
    localparam int RDL = 1;
    localparam int RSL = 2;
    localparam int WAW = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] num_hv = '0;
    logic          busy, finished, error, rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          bnd_valid, bnd_first, bnd_last, bnd_ready, bnd_done;
    logic [DW-1:0] bnd_data, bnd_data_out;
    logic          wr_en;
    logic [WAW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    always #5 clk = ~clk;

    hv_bundle_sequencer #(
        .HV_DATA_WIDTH(DW), .HV_DIM(DIM), .ADDR_WIDTH(AW),
        .CNT_WIDTH(CW), .RD_LAT(RDL), .RES_LAT(RSL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .num_hv(num_hv), .busy(busy), .finished(finished), .error(error),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .bnd_valid(bnd_valid), .bnd_first(bnd_first), .bnd_last(bnd_last),
        .bnd_data(bnd_data), .bnd_ready(bnd_ready), .bnd_done(bnd_done),
        .bnd_data_out(bnd_data_out), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    // Source memory, one-cycle synchronous read
    logic [DW-1:0] mem [0:1023];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr[9:0]];

    // Bundler model
    logic          float_mode = 1'b0;
    logic          force_low = 1'b0;
    logic          m_ready, m_done, m_odly;
    logic [DW-1:0] m_out, m_acc_i;
    real           m_acc_r;
    int            m_lat;

    function automatic real f2r(input logic [31:0] b);
        logic [10:0] e;
        if (b[30:23] == 8'd0) return 0.0;
        e = {3'b000, b[30:23]} + 11'd896;
        return $bitstoreal({b[31], e, b[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ready <= 1'b1; m_done <= 1'b1; m_odly <= 1'b0;
            m_out <= '0; m_acc_i <= '0; m_acc_r <= 0.0; m_lat <= 0;
        end else begin
            m_ready <= !bnd_valid;
            m_odly  <= 1'b0;
            if (bnd_valid) begin
                if (bnd_first) begin
                    m_acc_i <= bnd_data; m_acc_r <= f2r(bnd_data); m_done <= 1'b0;
                end else begin
                    m_acc_i <= m_acc_i + bnd_data; m_acc_r <= m_acc_r + f2r(bnd_data);
                end
                if (bnd_last) m_lat <= 3;
            end else if (m_lat != 0) begin
                m_lat <= m_lat - 1;
                if (m_lat == 1) begin m_done <= 1'b1; m_odly <= 1'b1; end
            end
            if (m_odly) m_out <= float_mode ? r2f(m_acc_r) : m_acc_i;
        end
    end
    assign bnd_ready    = m_ready & ~force_low;
    assign bnd_done     = m_done;
    assign bnd_data_out = m_out;

    // Event monitor
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0]  rd_q[$];
    logic [33:0]    beat_q[$];
    logic [33:0]    wr_q[$];
    int             wr_cyc[$];
    int             fin_cnt = 0, fin_cyc = 0, err_cnt = 0, vld_viol = 0;
    logic           prev_vld = 1'b0;

    always @(negedge clk) begin
        if (rd_en)     rd_q.push_back(rd_addr);
        if (bnd_valid) beat_q.push_back({bnd_first, bnd_last, bnd_data});
        if (wr_en) begin
            wr_q.push_back({wr_addr, wr_data});
            wr_cyc.push_back(cyc);
        end
        if (finished) begin fin_cnt <= fin_cnt + 1; fin_cyc <= cyc; end
        if (error)    err_cnt <= err_cnt + 1;
        if (bnd_valid && prev_vld) vld_viol <= vld_viol + 1;
        prev_vld <= bnd_valid;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [CW-1:0] n);
        @(posedge clk); #1;
        base_addr = b; num_hv = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_fin(input int f_start, input int max_cyc, input string tag);
        int n = 0;
        while (fin_cnt == f_start && n < max_cyc) begin
            @(posedge clk); n++;
        end
        check_eq(tag, (fin_cnt != f_start) ? 32'd1 : 32'd0, 32'd1);
        #1;
    endtask

    initial begin
        int r0, b0, w0, f0, e0, n;
        for (int i = 0; i < 1024; i++)
            mem[i] = (i >= 256 && i < 512) ? DW'(i - 256) : '0;
        mem[10'h200] = 32'h3F000000; mem[10'h204] = 32'hBE800000;
        mem[10'h201] = 32'h3F800000; mem[10'h205] = 32'h3F800000;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rd_en", rd_en, 0);
        check_eq("rst_valid", bnd_valid, 0);
        check_eq("rst_last", bnd_last, 0);
        check_eq("rst_wr_en", wr_en, 0);
        check_eq("rst_fin_err", {finished, error}, 0);
        check_eq("rst_rd_addr", rd_addr, 0);
        @(posedge clk); #1 reset_n = 1'b1;

        // Main run: num_hv=3, base 0x100, busy start and base change ignored
        r0 = rd_q.size(); b0 = beat_q.size(); w0 = wr_q.size(); f0 = fin_cnt; e0 = err_cnt;
        do_start(16'h0100, 8'd3);
        base_addr = 16'h0300; num_hv = 8'd5;
        repeat (6) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_fin(f0, 2000, "t1_finished");
        check_eq("t1_rd_count", rd_q.size() - r0, 12);
        if (rd_q.size() - r0 == 12)
            for (int d = 0; d < 4; d++)
                for (int k = 0; k < 3; k++)
                    check_eq($sformatf("t1_rd_addr_d%0d_k%0d", d, k), rd_q[r0 + d*3 + k], 32'h100 + k*4 + d);
        check_eq("t1_beat_count", beat_q.size() - b0, 12);
        if (beat_q.size() - b0 == 12)
            for (int d = 0; d < 4; d++)
                for (int k = 0; k < 3; k++) begin
                    n = b0 + d*3 + k;
                    check_eq($sformatf("t1_first_d%0d_k%0d", d, k), beat_q[n][33], (k == 0) ? 1 : 0);
                    check_eq($sformatf("t1_last_d%0d_k%0d", d, k), beat_q[n][32], (k == 2) ? 1 : 0);
                    check_eq($sformatf("t1_data_d%0d_k%0d", d, k), beat_q[n][31:0], k*4 + d);
                end
        check_eq("t1_wr_count", wr_q.size() - w0, 4);
        if (wr_q.size() - w0 == 4) begin
            for (int d = 0; d < 4; d++) begin
                check_eq($sformatf("t1_wr_addr_%0d", d), wr_q[w0 + d][33:32], d);
                check_eq($sformatf("t1_wr_data_%0d", d), wr_q[w0 + d][31:0], 12 + 3*d);
            end
            check_eq("t1_fin_after_wr", fin_cyc - wr_cyc[w0 + 3], 1);
        end
        check_eq("t1_fin_count", fin_cnt - f0, 1);
        check_eq("t1_busy_after", busy, 0);
        check_eq("t1_no_error", err_cnt - e0, 0);

        // IEEE-754 bundle: +0.5 + -0.25
        float_mode = 1'b1;
        w0 = wr_q.size(); f0 = fin_cnt;
        do_start(16'h0200, 8'd2);
        wait_fin(f0, 2000, "t2_finished");
        check_eq("t2_wr_count", wr_q.size() - w0, 4);
        if (wr_q.size() - w0 == 4) begin
            check_eq("t2_wr_addr0", wr_q[w0][33:32], 0);
            check_eq("t2_wr_data0", wr_q[w0][31:0], 32'h3E800000);
            check_eq("t2_wr_data1", wr_q[w0 + 1][31:0], 32'h40000000);
            check_eq("t2_wr_data2", wr_q[w0 + 2][31:0], 32'h0);
        end
        float_mode = 1'b0;

        // Illegal starts
        r0 = rd_q.size(); e0 = err_cnt;
        for (int t = 0; t < 2; t++) begin
            @(posedge clk); #1 num_hv = (t == 0) ? 8'd1 : 8'd0; start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            check_eq($sformatf("err_pulse_n%0d", 1 - t), error, 1);
            check_eq($sformatf("err_busy_n%0d", 1 - t), busy, 0);
            @(negedge clk);
            check_eq($sformatf("err_drop_n%0d", 1 - t), error, 0);
        end
        repeat (5) @(posedge clk); #1;
        check_eq("err_no_rd", rd_q.size() - r0, 0);
        check_eq("err_count", err_cnt - e0, 2);

        // Ready held low in S_ISSUE
        r0 = rd_q.size(); b0 = beat_q.size(); w0 = wr_q.size(); f0 = fin_cnt;
        force_low = 1'b1;
        do_start(16'h0105, 8'd2);
        repeat (20) @(posedge clk); #1;
        check_eq("stall_no_beat", beat_q.size() - b0, 0);
        check_eq("stall_one_rd", rd_q.size() - r0, 1);
        check_eq("stall_bnd_data", bnd_data, 5);
        force_low = 1'b0;
        repeat (3) @(posedge clk); #1;
        check_eq("stall_one_beat", beat_q.size() - b0, 1);
        if (beat_q.size() - b0 >= 1) begin
            check_eq("stall_beat_data", beat_q[b0][31:0], 5);
            check_eq("stall_beat_first", beat_q[b0][33], 1);
        end
        wait_fin(f0, 2000, "stall_finished");
        if (wr_q.size() - w0 >= 1)
            check_eq("stall_wr0", wr_q[w0][31:0], 14);
        else
            check_eq("stall_wr_count", wr_q.size() - w0, 4);

        // Reset in the d=1 S_DONE_WAIT, then a fresh run
        b0 = beat_q.size(); w0 = wr_q.size(); f0 = fin_cnt;
        do_start(16'h0100, 8'd2);
        n = 0;
        while (beat_q.size() - b0 < 4 && n < 500) begin @(posedge clk); n++; end
        check_eq("rmid_reached", (beat_q.size() - b0 >= 4) ? 1 : 0, 1);
        @(negedge clk);
        check_eq("rmid_last_before", bnd_last, 1);
        reset_n = 1'b0;
        #1;
        check_eq("rmid_busy", busy, 0);
        check_eq("rmid_last", bnd_last, 0);
        check_eq("rmid_rd_addr", rd_addr, 0);
        check_eq("rmid_wr_addr", wr_addr, 0);
        check_eq("rmid_bnd_data", bnd_data, 0);
        check_eq("rmid_wr_data", wr_data, 0);
        repeat (3) @(posedge clk); #1;
        check_eq("rmid_wr_count", wr_q.size() - w0, 1);
        check_eq("rmid_no_fin", fin_cnt - f0, 0);
        reset_n = 1'b1;
        w0 = wr_q.size(); f0 = fin_cnt;
        do_start(16'h0100, 8'd2);
        wait_fin(f0, 2000, "rmid_fresh_finished");
        check_eq("rmid_fresh_wr_count", wr_q.size() - w0, 4);
        if (wr_q.size() - w0 == 4) begin
            check_eq("rmid_fresh_addr3", wr_q[w0 + 3][33:32], 3);
            check_eq("rmid_fresh_data3", wr_q[w0 + 3][31:0], 10);
        end
        check_eq("valid_single_cycle", vld_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
